// File: rtl/game_pkg.sv
// Shared constants for the Jack-Frost game blocks: PS/2 set-2 scan codes,
// vertical motion states, and bit positions inside blue_state.
package game_pkg;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } vstate_t;

  localparam int BS_FACING = 0;
  localparam int BS_AIR    = 1;
  localparam int BS_MOVING = 2;

endpackage

// File: rtl/ps2_key_tracker.sv
// Held-key tracker fed by the ps2_keyboard byte FIFO.
// Pops one byte per key_valid, follows F0 (break) prefixes, skips E0,
// keeps held bits for W/A/D and latches a jump request on a fresh W make.
// The request is consumed by the next frame_tick; a make arriving in the
// same cycle as the tick survives so that it feeds the following tick.
module ps2_key_tracker
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       frame_tick,
  output logic       key_rd,
  output logic       held_a,
  output logic       held_d,
  output logic       jump_req
);

  logic brk;
  logic held_w;
  logic pop;

  // A byte is taken only when the previous pop strobe is not still high,
  // which stops the same FIFO entry being consumed twice.
  assign pop = key_valid && !key_rd;

  // Pop handshake, break flag, held bits and jump request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_rd   <= 1'b0;
      brk      <= 1'b0;
      held_w   <= 1'b0;
      held_a   <= 1'b0;
      held_d   <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      key_rd <= pop;
      if (frame_tick) jump_req <= 1'b0;
      if (pop) begin
        case (key_code)
          KEY_BREAK: brk <= 1'b1;
          KEY_EXT:   ;
          KEY_W: begin
            brk <= 1'b0;
            if (brk) begin
              held_w <= 1'b0;
            end else begin
              held_w <= 1'b1;
              // Typematic repeats arrive while W is already held.
              if (!held_w) jump_req <= 1'b1;
            end
          end
          KEY_A: begin
            brk    <= 1'b0;
            held_a <= !brk;
          end
          KEY_D: begin
            brk    <= 1'b0;
            held_d <= !brk;
          end
          default: brk <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/player_motion.sv
// Player movement engine: held-key tracking, bounded horizontal motion and
// a frame-tick jump/gravity state machine driving x/y and blue_state.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra mid-air jump,
// re-armed on landing). Without it airborne jump requests are dropped.
module player_motion
  import game_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int V_W      = 5,
  parameter int X_INIT   = 0,
  parameter int X_MAX    = 504,
  parameter int Y_GROUND = 333,
  parameter int SPEED    = 2,
  parameter int JUMP_V   = 9,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_valid,
  input  logic [7:0]     key_code,
  output logic           key_rd,
  input  logic           frame_tick,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [2:0]     blue_state,
  output logic           landed,
  output logic           jumped
);

  // Constants sized one bit wider than the coordinates so that the
  // arithmetic below can see borrow/overflow before clamping.
  localparam logic [X_W:0]        SPD_W   = (X_W+1)'(SPEED);
  localparam logic [X_W:0]        XMAX_W  = (X_W+1)'(X_MAX);
  localparam logic [X_W-1:0]      XINIT   = X_W'(X_INIT);
  localparam logic [Y_W:0]        YG_W    = (Y_W+1)'(Y_GROUND);
  localparam logic signed [V_W-1:0] JUMP_S  = V_W'(JUMP_V);
  localparam logic signed [V_W:0]   GRAV_S1 = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   VMAX_S1 = (V_W+1)'(V_MAX);

  logic held_a, held_d, jump_req;

  ps2_key_tracker u_keys (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .frame_tick (frame_tick),
    .key_rd     (key_rd),
    .held_a     (held_a),
    .held_d     (held_d),
    .jump_req   (jump_req)
  );

  vstate_t                vstate, vs_n;
  logic signed [V_W-1:0]  vy, vy_n;
  logic                   facing, facing_n, moving;
  logic [X_W-1:0]         x_n;
  logic [Y_W-1:0]         y_n;
  logic                   land_n, jump_n;

  logic [X_W:0]           x_left, x_right;
  logic [Y_W:0]           y_up, y_dn;
  logic signed [V_W:0]    vy_dec1, vy_inc1;
  logic signed [V_W-1:0]  vy_fall;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic dj_armed, dj_n;
`endif

  // Horizontal step: held A or D alone moves and turns, both/neither holds.
  always_comb begin
    x_left   = {1'b0, x_pos} - SPD_W;
    x_right  = {1'b0, x_pos} + SPD_W;
    x_n      = x_pos;
    facing_n = facing;
    if (held_a && !held_d) begin
      x_n      = x_left[X_W] ? '0 : x_left[X_W-1:0];
      facing_n = 1'b0;
    end else if (held_d && !held_a) begin
      x_n      = (x_right > XMAX_W) ? XMAX_W[X_W-1:0] : x_right[X_W-1:0];
      facing_n = 1'b1;
    end
  end

  // Vertical next state: rise decelerates, fall accelerates up to V_MAX.
  always_comb begin
    vs_n    = vstate;
    vy_n    = vy;
    y_n     = y_pos;
    land_n  = 1'b0;
    jump_n  = 1'b0;
    vy_dec1 = {vy[V_W-1], vy} - GRAV_S1;
    vy_inc1 = {vy[V_W-1], vy} + GRAV_S1;
    vy_fall = (vy_inc1 > VMAX_S1) ? VMAX_S1[V_W-1:0] : vy_inc1[V_W-1:0];
    y_up    = {1'b0, y_pos} - {{(Y_W+1-V_W){1'b0}}, vy};
    y_dn    = {1'b0, y_pos} + {{(Y_W+1-V_W){1'b0}}, vy_fall};
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_n    = dj_armed;
`endif
    case (vstate)
      GROUND: begin
        if (jump_req) begin
          vs_n   = RISE;
          vy_n   = JUMP_S;
          jump_n = 1'b1;
        end
      end
      RISE: begin
        if (y_up[Y_W]) begin
          // Would pass the top of the screen: pin to 0 and start falling.
          y_n  = '0;
          vy_n = '0;
          vs_n = FALL;
        end else begin
          y_n = y_up[Y_W-1:0];
          if (vy_dec1[V_W] || vy_dec1 == '0) begin
            vy_n = '0;
            vs_n = FALL;
          end else begin
            vy_n = vy_dec1[V_W-1:0];
          end
        end
      end
      FALL: begin
        vy_n = vy_fall;
        if (y_dn >= YG_W) begin
          y_n    = YG_W[Y_W-1:0];
          vy_n   = '0;
          vs_n   = GROUND;
          land_n = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
          dj_n   = 1'b1;
`endif
        end else begin
          y_n = y_dn[Y_W-1:0];
        end
      end
      default: begin
        vs_n = GROUND;
        vy_n = '0;
      end
    endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
    // Mid-air jump replaces this tick's physics step with a fresh takeoff.
    if (vstate != GROUND && jump_req && dj_armed) begin
      vs_n   = RISE;
      vy_n   = JUMP_S;
      y_n    = y_pos;
      land_n = 1'b0;
      jump_n = 1'b1;
      dj_n   = 1'b0;
    end
`endif
  end

  // Physics registers advance on frame_tick; pulses last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos    <= XINIT;
      y_pos    <= YG_W[Y_W-1:0];
      vy       <= '0;
      vstate   <= GROUND;
      facing   <= 1'b1;
      moving   <= 1'b0;
      landed   <= 1'b0;
      jumped   <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_armed <= 1'b1;
`endif
    end else begin
      landed <= frame_tick && land_n;
      jumped <= frame_tick && jump_n;
      if (frame_tick) begin
        x_pos    <= x_n;
        facing   <= facing_n;
        moving   <= (x_n != x_pos);
        y_pos    <= y_n;
        vy       <= vy_n;
        vstate   <= vs_n;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_armed <= dj_n;
`endif
      end
    end
  end

  assign blue_state[BS_FACING] = facing;
  assign blue_state[BS_AIR]    = (vstate != GROUND);
  assign blue_state[BS_MOVING] = moving;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with hand-computed expectations.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_rd;
  logic       frame_tick;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic [2:0] blue_state;
  logic       landed, jumped;

  int checks = 0;
  int errors = 0;

`ifdef PLAYER_DOUBLE_JUMP_EN
  localparam int DJ = 1;
`else
  localparam int DJ = 0;
`endif

  player_motion dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_rd     (key_rd),
    .frame_tick (frame_tick),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .blue_state (blue_state),
    .landed     (landed),
    .jumped     (jumped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    int ymin, land_at, lc, jc;
    bit done;
    reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 333);
    chk("rst_bs", blue_state, 3'b001);
    chk("rst_rd", key_rd, 0);
    chk("rst_land", landed, 0);
    chk("rst_jump", jumped, 0);

    // D make, 10 ticks right
    send(8'h23);
    chk("pop_rd", key_rd, 1);
    repeat (10) tick();
    chk("d10_x", x_pos, 20);
    chk("d10_bs", blue_state, 3'b101);
    send(8'hF0); send(8'h23);
    tick();
    chk("drel_x", x_pos, 20);
    chk("drel_bs", blue_state, 3'b001);

    // A held to the left wall, then pinned at 0
    send(8'h1C);
    repeat (10) tick();
    chk("a10_x", x_pos, 0);
    repeat (3) tick();
    chk("a_sat_x", x_pos, 0);
    chk("a_sat_bs", blue_state, 3'b000);
    send(8'hF0); send(8'h1C);

    // D held up to the right wall
    send(8'h23);
    repeat (251) tick();
    chk("d_502", x_pos, 502);
    tick();
    chk("d_504", x_pos, 504);
    chk("d_504_bs", blue_state, 3'b101);
    tick();
    chk("d_sat_x", x_pos, 504);
    chk("d_sat_bs", blue_state, 3'b001);
    send(8'hF0); send(8'h23);

    // Jump: takeoff tick, then trajectory up to landing
    send(8'h1D);
    tick();
    chk("tko_jumped", jumped, 1);
    chk("tko_y", y_pos, 333);
    chk("tko_air", blue_state[1], 1);
    tick();
    chk("r1_y", y_pos, 324);
    chk("r1_jumped", jumped, 0);
    send(8'h1D); send(8'h1D); send(8'h1D);
    ymin = 324; land_at = 0; lc = 0; jc = 0; done = 0;
    for (int k = 3; k <= 40 && !done; k++) begin
      tick();
      if (jumped) jc++;
      if (int'(y_pos) < ymin) ymin = int'(y_pos);
      if (landed) begin lc++; land_at = k; done = 1; end
    end
    chk("land_tick", land_at, 19);
    chk("apex_y", ymin, 288);
    chk("repeat_nojump", jc, 0);
    chk("land_y", y_pos, 333);
    chk("land_air", blue_state[1], 0);
    tick();
    if (landed) lc++;
    chk("land_once", lc, 1);
    chk("ground_y", y_pos, 333);

    // Fresh W make mid-air
    send(8'hF0); send(8'h1D);
    send(8'h1D);
    tick();
    chk("j2_jumped", jumped, 1);
    tick();
    chk("j2_y", y_pos, 324);
    send(8'hF0); send(8'h1D); send(8'h1D);
    tick();
    chk("air_make_jumped", jumped, DJ);
    chk("air_make_y", y_pos, DJ ? 324 : 316);
    send(8'hF0); send(8'h1D); send(8'h1D);
    tick();
    chk("air_make2_jumped", jumped, 0);
    chk("air_make2_y", y_pos, DJ ? 315 : 309);

    // Reset mid-rise with a break prefix pending
    send(8'hF0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_y", y_pos, 333);
    chk("mid_rst_x", x_pos, 0);
    chk("mid_rst_bs", blue_state, 3'b001);
    chk("mid_rst_land", landed, 0);

    // D make coincident with tick: applies to the next tick only
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'h23; frame_tick = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; frame_tick = 1'b0;
    chk("coin_x", x_pos, 0);
    chk("coin_bs", blue_state, 3'b001);
    tick();
    chk("coin_next_x", x_pos, 2);
    chk("coin_next_bs", blue_state, 3'b101);

    // key_valid held two cycles: one pop, no double strobe
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'hE0;
    @(negedge clk);
    chk("hold_rd1", key_rd, 1);
    @(negedge clk);
    chk("hold_rd2", key_rd, 0);
    key_valid = 1'b0;

    // E0-prefixed break of D, then E0-prefixed A make
    send(8'hE0); send(8'hF0); send(8'h23);
    tick();
    chk("e0_rel_x", x_pos, 2);
    chk("e0_rel_bs", blue_state, 3'b001);
    send(8'hE0); send(8'h1C);
    tick();
    chk("e0_a_x", x_pos, 0);
    chk("e0_a_bs", blue_state, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
